// File: rtl/irq_request_capture_pkg.sv
// Shared constants and types for the interrupt request capture stage.
package irq_request_capture_pkg;

  // Eight lines to match the downstream 8-input priority encoder
  localparam int N_IRQ = 8;
  localparam int IDX_W = 3;

  // Offer handshake FSM
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    GAP   = 2'd2
  } state_t;

  // edge_mode encoding per line
  localparam logic EDGE  = 1'b1;
  localparam logic LEVEL = 1'b0;

endpackage

// File: rtl/irq_line_sync.sv
// Multi-stage synchroniser for all request lines plus a one-cycle history of
// the synchronised value, used for rising-edge detection downstream.
module irq_line_sync
  import irq_request_capture_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_in,
  output logic [N_IRQ-1:0] s,
  output logic [N_IRQ-1:0] s_d
);

  // Stage 0 samples the raw pads; the last stage is the stable value
  logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_reg;
  logic [N_IRQ-1:0]                  s_d_reg;

  // Shift the raw lines through the synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], irq_in};
    end
  end

  // Remember the previous synchronised value for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d_reg <= '0;
    end else begin
      s_d_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign s   = sync_reg[SYNC_STAGES-1];
  assign s_d = s_d_reg;

endmodule

// File: rtl/irq_request_capture.sv
// Captures eight asynchronous request lines into a pending register and
// offers a masked snapshot to the priority encoder under valid/ack.
// The encoder's winning index clears exactly one pending bit per handshake.
module irq_request_capture
  import irq_request_capture_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] edge_mode,
  input  logic [N_IRQ-1:0] mask,
  output logic [N_IRQ-1:0] req_vec,
  output logic             req_valid,
  input  logic             ack,
  input  logic [IDX_W-1:0] grant_idx,
  output logic [N_IRQ-1:0] pending,
  output logic             ack_err
);

  logic [N_IRQ-1:0] s;
  logic [N_IRQ-1:0] s_d;
  logic [N_IRQ-1:0] set_vec;
  logic [N_IRQ-1:0] clr_vec;
  logic [N_IRQ-1:0] offerable;
  logic             offer_ack;

  state_t           state_reg, state_next;
  logic [N_IRQ-1:0] pending_reg, pending_next;
  logic [N_IRQ-1:0] req_vec_reg, req_vec_next;
  logic             req_valid_reg, req_valid_next;
  logic             ack_err_reg, ack_err_next;

  irq_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .irq_in (irq_in),
    .s      (s),
    .s_d    (s_d)
  );

  // An ack only counts while an offer is outstanding
  assign offer_ack = (state_reg == OFFER) && ack;
  assign offerable = pending_reg & ~mask;

  // Per-line set (edge or level) and clear (granted bit of the held offer)
  generate
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_line
      assign set_vec[gi] = (edge_mode[gi] == EDGE) ? (s[gi] & ~s_d[gi]) : s[gi];
      assign clr_vec[gi] = offer_ack && (grant_idx == IDX_W'(gi)) && req_vec_reg[gi];
    end
  endgenerate

  // Set wins over clear so an edge landing on the ack cycle is kept
  assign pending_next = set_vec | (pending_reg & ~clr_vec);

  // A grant pointing at an empty slot of the offer is flagged for one cycle
  assign ack_err_next = offer_ack && !req_vec_reg[grant_idx];

  // Offer FSM: snapshot in IDLE, hold during OFFER, one settle cycle in GAP
  always_comb begin
    state_next     = state_reg;
    req_vec_next   = req_vec_reg;
    req_valid_next = req_valid_reg;
    case (state_reg)
      IDLE: begin
        if (offerable != '0) begin
          req_vec_next   = offerable;
          req_valid_next = 1'b1;
          state_next     = OFFER;
        end
      end
      OFFER: begin
        if (ack) begin
          req_valid_next = 1'b0;
          state_next     = GAP;
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        req_valid_next = 1'b0;
        state_next     = IDLE;
      end
    endcase
  end

  // State, pending and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pending_reg   <= '0;
      req_vec_reg   <= '0;
      req_valid_reg <= 1'b0;
      ack_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pending_reg   <= pending_next;
      req_vec_reg   <= req_vec_next;
      req_valid_reg <= req_valid_next;
      ack_err_reg   <= ack_err_next;
    end
  end

  assign req_vec   = req_vec_reg;
  assign req_valid = req_valid_reg;
  assign pending   = pending_reg;
  assign ack_err   = ack_err_reg;

endmodule

// File: tb/tb_irq_request_capture.sv
// Self-checking bench for irq_request_capture: directed scenarios followed by
// a randomized run, all compared each cycle against a behavioural model.
module tb_irq_request_capture;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_in;
  logic [7:0] edge_mode;
  logic [7:0] mask;
  logic [7:0] req_vec;
  logic       req_valid;
  logic       ack;
  logic [2:0] grant_idx;
  logic [7:0] pending;
  logic       ack_err;

  int checks   = 0;
  int failures = 0;
  int offers   = 0;

  // Behavioural model state
  logic [7:0] dly [SYNC];   // irq_in as seen SYNC cycles later
  logic [7:0] m_sd;         // previous synchronised value
  logic [7:0] m_pend;
  logic [7:0] m_req;
  bit         m_valid;
  int         m_hold;       // idle cycles still owed after an accepted offer
  bit         m_err;

  irq_request_capture #(.SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .edge_mode (edge_mode),
    .mask      (mask),
    .req_vec   (req_vec),
    .req_valid (req_valid),
    .ack       (ack),
    .grant_idx (grant_idx),
    .pending   (pending),
    .ack_err   (ack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) dly[i] = 8'h00;
    m_sd = 8'h00; m_pend = 8'h00; m_req = 8'h00;
    m_valid = 1'b0; m_hold = 0; m_err = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".pending"},   pending,            m_pend);
    chk({tag, ".req_vec"},   req_vec,            m_req);
    chk({tag, ".req_valid"}, {7'd0, req_valid},  {7'd0, m_valid});
    chk({tag, ".ack_err"},   {7'd0, ack_err},    {7'd0, m_err});
  endtask

  // Advance one clock: update the model with the inputs present at the edge,
  // then compare every output 1 ns later.
  task automatic step(input string tag);
    logic [7:0] s_now, set_v, clr_v;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      s_now = dly[SYNC-1];
      set_v = (edge_mode & s_now & ~m_sd) | (~edge_mode & s_now);
      clr_v = 8'h00;
      m_err = 1'b0;
      if (m_valid && ack) begin
        if (m_req[grant_idx]) clr_v = 8'h01 << grant_idx;
        else                  m_err = 1'b1;
      end
      if (m_valid) begin
        if (ack) begin m_valid = 1'b0; m_hold = 1; end
      end else if (m_hold > 0) begin
        m_hold--;
      end else if ((m_pend & ~mask) != 8'h00) begin
        m_req   = m_pend & ~mask;
        m_valid = 1'b1;
      end
      m_pend = set_v | (m_pend & ~clr_v);
      for (int i = SYNC - 1; i > 0; i--) dly[i] = dly[i-1];
      dly[0] = irq_in;
      m_sd   = s_now;
    end
    #1;
    compare_all(tag);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 12 && !req_valid; i++) step(tag);
    chk({tag, ".wait_valid"}, {7'd0, req_valid}, 8'h01);
    if (req_valid) offers++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; irq_in = 8'h00; ack = 1'b0; grant_idx = 3'd0; mask = 8'h00;
    #1;
    model_reset();
    step("rst"); step("rst");
    rst_n = 1'b1;
  endtask

  task automatic do_ack(input string tag, input logic [2:0] idx);
    ack = 1'b1; grant_idx = idx;
    step(tag);
    ack = 1'b0;
  endtask

  function automatic logic [2:0] top_idx(input logic [7:0] v);
    logic [2:0] r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  initial begin
    rst_n = 1'b0; irq_in = 8'hFF; edge_mode = 8'hFF; mask = 8'h00;
    ack = 1'b0; grant_idx = 3'd0;
    #1;
    model_reset();

    // Reset holds everything at zero even with all lines high
    for (int i = 0; i < 3; i++) begin
      step("reset_hold");
      chk("reset_hold.pending", pending, 8'h00);
      chk("reset_hold.valid", {7'd0, req_valid}, 8'h00);
    end
    rst_n = 1'b1;
    step("rel0"); step("rel1"); step("rel2");
    chk("latency.pending_e2", pending, 8'hFF);
    chk("latency.valid_e2", {7'd0, req_valid}, 8'h00);
    step("rel3");
    chk("latency.valid_e3", {7'd0, req_valid}, 8'h01);
    chk("latency.req_e3", req_vec, 8'hFF);

    // Edge capture of a single-cycle pulse on line 5
    do_reset();
    edge_mode = 8'hFF;
    irq_in = 8'h20; step("edge");
    irq_in = 8'h00;
    wait_valid("edge");
    chk("edge.req", req_vec, 8'h20);
    do_ack("edge_ack", 3'd5);
    chk("edge.pending_clr", pending, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step("edge_quiet");
      chk("edge.no_reoffer", {7'd0, req_valid}, 8'h00);
    end

    // Priority drain of 8'h91, top index first
    do_reset();
    offers = 0;
    irq_in = 8'h91; step("drain");
    irq_in = 8'h00;
    wait_valid("drain1"); chk("drain.req1", req_vec, 8'h91); do_ack("drain_ack", 3'd7);
    chk("drain.gap1", {7'd0, req_valid}, 8'h00);
    step("drain_gap");
    chk("drain.gap2", {7'd0, req_valid}, 8'h00);
    wait_valid("drain2"); chk("drain.req2", req_vec, 8'h11); do_ack("drain_ack", 3'd4);
    wait_valid("drain3"); chk("drain.req3", req_vec, 8'h01); do_ack("drain_ack", 3'd0);
    for (int i = 0; i < 6; i++) step("drain_idle");
    chk("drain.idle", {7'd0, req_valid}, 8'h00);
    chk("drain.offer_count", 8'(offers), 8'd3);

    // Set/clear collision on bit 3
    do_reset();
    irq_in = 8'h08; step("coll");
    irq_in = 8'h00;
    wait_valid("coll1");
    chk("coll.req1", req_vec, 8'h08);
    irq_in = 8'h08; step("coll_sync"); step("coll_sync");
    do_ack("coll_ack", 3'd3);
    irq_in = 8'h00;
    chk("coll.pending_kept", pending, 8'h08);
    wait_valid("coll2");
    chk("coll.req2", req_vec, 8'h08);

    // Mask change during OFFER; level lines 1 and 2 held high
    do_reset();
    edge_mode = 8'hF9; irq_in = 8'h06;
    wait_valid("mask1");
    chk("mask.req1", req_vec, 8'h06);
    mask = 8'h04; step("mask_hold");
    chk("mask.stable", req_vec, 8'h06);
    do_ack("mask_ack", 3'd2);
    wait_valid("mask2");
    chk("mask.req2", req_vec, 8'h02);
    chk("mask.pending", pending, 8'h06);
    irq_in = 8'h00; edge_mode = 8'hFF;

    // Grant index pointing at a zero bit
    do_reset();
    irq_in = 8'h01; step("bad");
    irq_in = 8'h00;
    wait_valid("bad1");
    chk("bad.req1", req_vec, 8'h01);
    do_ack("bad_ack", 3'd7);
    chk("bad.ack_err", {7'd0, ack_err}, 8'h01);
    chk("bad.pending", pending, 8'h01);
    step("bad_gap");
    chk("bad.ack_err_pulse", {7'd0, ack_err}, 8'h00);
    wait_valid("bad2");
    chk("bad.req2", req_vec, 8'h01);

    // Randomized traffic, model-checked every cycle
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) == 0) irq_in = 8'($urandom);
      if ($urandom_range(0, 15) == 0) edge_mode = 8'($urandom);
      if ($urandom_range(0, 7) == 0) mask = 8'($urandom);
      ack = ($urandom_range(0, 3) == 0);
      grant_idx = ($urandom_range(0, 4) == 0) ? 3'($urandom) : top_idx(m_req);
      step("rand");
    end
    ack = 1'b0;

    // Reset asserted mid-offer drops everything immediately
    do_reset();
    edge_mode = 8'hFF; irq_in = 8'h42; step("rmid");
    irq_in = 8'h00;
    wait_valid("rmid");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmid.valid", {7'd0, req_valid}, 8'h00);
    chk("rmid.pending", pending, 8'h00);
    chk("rmid.req", req_vec, 8'h00);
    model_reset();
    step("rmid_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step("rmid_after");
    chk("rmid.no_offer", {7'd0, req_valid}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_request_capture.md
Name: irq_request_capture

Overview:
- Upstream stage of the 8-input priority encoder: turns eight raw asynchronous interrupt/request lines into a stable, masked 8-bit request vector for the encoder.
- Synchronises inputs and detects edges or levels per line, holds pending bits, and offers a snapshot under a valid/ack handshake.
- Takes back the encoder's 3-bit winning index and clears only that pending bit.
- Sits between pad-level request lines and the encoder/service logic.

Parameters:
- N_IRQ, 8, number of request lines; fixed at 8 to match the encoder's 8-bit input and 3-bit index.
- SYNC_STAGES, 2, synchroniser depth per line; legal values are 2 or 3.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- irq_in  input  8  raw request lines, asynchronous to clk.
- edge_mode  input  8  per line: 1 = rising-edge capture, 0 = level capture.
- mask  input  8  per line: 1 = masked (kept pending but not offered).
- req_vec  output  8  snapshot of pending & ~mask; drives the encoder input.
- req_valid  output  1  req_vec is valid and stable.
- ack  input  1  consumer accepts the current offer.
- grant_idx  input  3  encoder result, sampled only when ack=1.
- pending  output  8  live pending register, for status/debug.
- ack_err  output  1  one-cycle pulse: ack arrived with grant_idx pointing at a zero bit of req_vec.

Behaviour:
- Reset (rst_n=0, asynchronous): all synchroniser flops, the edge-history register, pending, req_vec, req_valid and ack_err go to 0. The FSM goes to IDLE. Deassertion takes effect at the next clk edge; all logic is clocked.
- Synchroniser: SYNC_STAGES flops per line; s = last stage. An edge-history register s_d holds the previous value of s.
- Set condition per bit i:
  - edge_mode[i]=1: set_i = s[i] & ~s_d[i].
  - edge_mode[i]=0: set_i = s[i].
- Pending update per bit, each cycle: pending[i] <= set_i | (pending[i] & ~clr_i).
  - Set wins over clear in the same cycle, so an edge arriving during ack is never lost.
- clr_i = 1 only when state=OFFER, ack=1, grant_idx=i and req_vec[i]=1.
- FSM states: IDLE, OFFER, GAP.
  - IDLE: if (pending & ~mask) != 0, then req_vec <= pending & ~mask, req_valid <= 1, go to OFFER. Otherwise stay; req_vec holds its last value and req_valid=0.
  - OFFER: req_vec and req_valid are held stable regardless of changes to mask or pending. When ack=1: apply clr, req_valid <= 0, go to GAP. When ack=0: stay.
  - GAP: one cycle for the cleared pending bit to settle, then go to IDLE.
- Latency (SYNC_STAGES=2): irq_in rises before edge 0, then s at edge 1, pending at edge 2, req_valid=1 after edge 3.
- Minimum spacing: req_valid is low for at least 2 cycles between consecutive offers (GAP, then IDLE).
- ack outside OFFER is ignored: no clear, no error.
- ack with req_vec[grant_idx]=0: no bit is cleared, the handshake still completes (goes to GAP), and ack_err pulses high for 1 cycle.
- Level mode: a line held high re-sets its pending bit on the cycle after it is cleared, so it is offered again. This is the intended behaviour.
- A masked pending bit stays pending and is offered once it is unmasked.
- Reset asserted mid-OFFER: the offer is dropped immediately and all pending bits are lost.

Decomposition:
- Shared package holds:
  - N_IRQ and the index width localparam (3).
  - The FSM state enum {IDLE, OFFER, GAP}, 2 bits.
  - The edge_mode encoding constants EDGE=1 and LEVEL=0.
- One natural sub-module: irq_line_sync, an 8-bit SYNC_STAGES synchroniser plus edge-history register, producing s and s_d. The FSM and the pending register stay in the top level.

Test Plan:
- Reset: drive irq_in=8'hFF with rst_n=0 -> pending=0, req_valid=0, req_vec=0 throughout. After release with edge_mode=8'hFF: pending=8'hFF at edge 2, req_valid=1 with req_vec=8'hFF at edge 3.
- Edge capture: edge_mode=8'hFF; pulse irq_in[5] for 1 cycle -> req_vec=8'h20. Ack with grant_idx=5 -> pending=0, req_valid low for 2 cycles, no further offer.
- Priority drain: pending=8'h91; ack each offer with the top-bit index -> successive req_vec = 8'h91, 8'h11, 8'h01, then idle. Exactly 3 offers.
- Set/clear collision: during an OFFER of 8'h08, ack grant_idx=3 in the same cycle a new edge sets bit 3 -> pending[3] stays 1, next offer req_vec=8'h08.
- Mask and stability: offer 8'h06 is live; change mask to 8'h04 while in OFFER -> req_vec stays 8'h06. Ack idx 2 -> next offer req_vec=8'h02, pending=8'h06 (bit 2 set again by level line, masked).
- Bad ack: offer 8'h01; ack with grant_idx=7 -> ack_err=1 for 1 cycle, pending unchanged at 8'h01, re-offered after GAP/IDLE.
